multicycle_control: RTL
=======================

Name: multicycle_control

Overview:
Main control FSM of the multicycle RV32I core. It sequences the shared datapath (ALU, IR, PC, register file, unified memory) across FETCH/DECODE/EXECUTE/MEM/WB steps. It drives the 2-bit ALUOp that the ALU control decoder expands. It also waits on a memory ready handshake and flags illegal opcodes.

Parameters:
RESET_STATE, 4'd0, state entered on reset (FETCH); must stay 0.

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-high reset
opcode  in  7  instruction[6:0] from IR; stable from DECODE until next FETCH
Zero  in  1  ALU zero flag (current-cycle ALU result)
mem_ready  in  1  memory access completes this cycle
PCWrite  out  1  PC load enable = (Zero & Branch) | PCUpdate
AdrSrc  out  1  memory address mux: 0 = PC, 1 = Result
MemWrite  out  1  memory write strobe
IRWrite  out  1  instruction register (and OldPC) load
ResultSrc  out  2  00 = ALUOut reg, 01 = Data reg, 10 = ALUResult
ALUSrcA  out  2  00 = PC, 01 = OldPC, 10 = rs1 reg A, 11 = zero
ALUSrcB  out  2  00 = rs2 reg B, 01 = immediate, 10 = constant 4
ALUOp  out  2  00 = add, 01 = sub (branch), 10 = decode funct fields
RegWrite  out  1  register file write enable
illegal_instr  out  1  one-cycle pulse on unsupported opcode
state  out  4  current state, for debug/bench

Behaviour:
- Moore FSM, 4-bit state register. All outputs are combinational decodes of state, plus mem_ready, Zero and opcode where noted. Only the state register is clocked.
- Reset asserted: state = FETCH immediately (async). While reset is high, PCWrite, IRWrite, MemWrite, RegWrite and illegal_instr are forced to 0. Mux selects take FETCH values. Deasserting reset mid-instruction abandons it, and the first cycle after reset is a FETCH.
- Default outputs in every state: all enables 0, selects 00, ALUOp 00, unless listed below.
- FETCH (0):
  - Outputs: AdrSrc 0, ALUSrcA 00, ALUSrcB 10, ResultSrc 10.
  - IRWrite = PCUpdate = mem_ready.
  - Stay while !mem_ready; go to DECODE when mem_ready.
- DECODE (1): ALUSrcA 01, ALUSrcB 01 (branch/jump target into ALUOut). Next state by opcode:
  - 0000011 or 0100011 -> MEMADR
  - 0110011 -> EXECUTER
  - 0010011 -> EXECUTEI
  - 1101111 -> JAL
  - 1100011 -> BEQ
  - any other opcode -> FETCH, with illegal_instr = 1 this cycle and no architectural write.
- MEMADR (2): ALUSrcA 10, ALUSrcB 01. Next: MEMREAD if opcode = 0000011, else MEMWRITE.
- MEMREAD (3): AdrSrc 1, ResultSrc 00. Stay until mem_ready, then MEMWB.
- MEMWB (4): ResultSrc 01, RegWrite 1 -> FETCH.
- MEMWRITE (5): AdrSrc 1, ResultSrc 00, MemWrite 1 held until mem_ready. Exit to FETCH on the mem_ready cycle.
- EXECUTER (6): ALUSrcA 10, ALUSrcB 00, ALUOp 10 -> ALUWB.
- EXECUTEI (7): ALUSrcA 10, ALUSrcB 01, ALUOp 10 -> ALUWB.
- ALUWB (8): ResultSrc 00, RegWrite 1 -> FETCH.
- JAL (9): ALUSrcA 01, ALUSrcB 10 (PC+4 computed), ResultSrc 00 (target), PCUpdate 1 -> ALUWB (rd = PC+4).
- BEQ (10):
  - Outputs: ALUSrcA 10, ALUSrcB 00, ALUOp 01, ResultSrc 00, Branch 1.
  - PCWrite = Zero in this cycle.
  - Next: FETCH.
- Unused encodings (11-15, or 11-15 minus EXECUTELUI when the feature is on) -> FETCH next cycle, with all enables 0.
- Latency (mem_ready tied 1, cycles FETCH-to-FETCH): R/I = 4, lw = 5, sw = 4, jal = 4, beq = 3, illegal = 2.
- Each additional cycle that mem_ready is low in FETCH/MEMREAD/MEMWRITE adds one cycle. No output enable toggles during a stall except MemWrite, which stays high.

Optional Feature:
MCTRL_LUI_EN
- Defined: DECODE sends opcode 0110111 to EXECUTELUI (11). In EXECUTELUI: ALUSrcA 11 (zero), ALUSrcB 01 (U-immediate), ALUOp 00 -> ALUWB. LUI latency is 4.
- Undefined: 0110111 is illegal (illegal_instr pulse, return to FETCH). State 11 is unused.

Test Plan:
- add (0110011), mem_ready = 1: state sequence 0,1,6,8,0. ALUOp = 10 in state 6. RegWrite = 1 only in state 8. IRWrite = 1 only in cycle 1.
- lw (0000011), mem_ready low for 2 cycles in MEMREAD: sequence 0,1,2,3,3,3,4,0. AdrSrc = 1 throughout state 3. RegWrite with ResultSrc = 01 in state 4.
- beq with Zero = 1, then Zero = 0: PCWrite = 1, then 0, in state 10. ALUOp = 01. Each instruction takes 3 cycles.
- opcode 0000000 at DECODE: illegal_instr high for exactly 1 cycle. No RegWrite/MemWrite. Next state is 0.
- reset pulsed during MEMWRITE: state = 0 immediately. MemWrite drops the same cycle. The next instruction fetch proceeds normally.
- With MCTRL_LUI_EN, opcode 0110111: sequence 0,1,11,8,0 with ALUSrcA = 11. Without the macro: illegal_instr pulse.

Source files
------------

// File: rtl/multicycle_control.sv
// Main control FSM for the multicycle RV32I core: sequences fetch/decode/execute/memory/writeback.
// Optional LUI support is compiled in when MCTRL_LUI_EN is defined.
module multicycle_control #(
  parameter logic [3:0] RESET_STATE = 4'd0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] opcode,
  input  logic       Zero,
  input  logic       mem_ready,
  output logic       PCWrite,
  output logic       AdrSrc,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic [1:0] ResultSrc,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ALUOp,
  output logic       RegWrite,
  output logic       illegal_instr,
  output logic [3:0] state
);

  localparam logic [3:0] FETCH      = 4'd0;
  localparam logic [3:0] DECODE     = 4'd1;
  localparam logic [3:0] MEMADR     = 4'd2;
  localparam logic [3:0] MEMREAD    = 4'd3;
  localparam logic [3:0] MEMWB      = 4'd4;
  localparam logic [3:0] MEMWRITE   = 4'd5;
  localparam logic [3:0] EXECUTER   = 4'd6;
  localparam logic [3:0] EXECUTEI   = 4'd7;
  localparam logic [3:0] ALUWB      = 4'd8;
  localparam logic [3:0] JAL        = 4'd9;
  localparam logic [3:0] BEQ        = 4'd10;
`ifdef MCTRL_LUI_EN
  localparam logic [3:0] EXECUTELUI = 4'd11;
`endif

  logic [3:0] state_r;
  logic [3:0] next_state_s;
  logic       branch_s;
  logic       pcupdate_s;
  logic       irwrite_s;
  logic       memwrite_s;
  logic       regwrite_s;
  logic       illegal_s;
  logic       adrsrc_s;
  logic [1:0] resultsrc_s;
  logic [1:0] alusrca_s;
  logic [1:0] alusrcb_s;
  logic [1:0] aluop_s;

  // State register; reset abandons any in-flight instruction and restarts at FETCH.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r <= RESET_STATE;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Next-state and per-state output decode.
  always_comb begin
    next_state_s = FETCH;
    branch_s     = 1'b0;
    pcupdate_s   = 1'b0;
    irwrite_s    = 1'b0;
    memwrite_s   = 1'b0;
    regwrite_s   = 1'b0;
    illegal_s    = 1'b0;
    adrsrc_s     = 1'b0;
    resultsrc_s  = 2'b00;
    alusrca_s    = 2'b00;
    alusrcb_s    = 2'b00;
    aluop_s      = 2'b00;
    case (state_r)
      FETCH: begin
        alusrcb_s   = 2'b10;
        resultsrc_s = 2'b10;
        irwrite_s   = mem_ready;
        pcupdate_s  = mem_ready;
        if (mem_ready) begin
          next_state_s = DECODE;
        end else begin
          next_state_s = FETCH;
        end
      end
      DECODE: begin
        // ALUOut captures OldPC + imm here so BEQ/JAL find their target ready.
        alusrca_s = 2'b01;
        alusrcb_s = 2'b01;
        case (opcode)
          7'b0000011, 7'b0100011: next_state_s = MEMADR;
          7'b0110011:             next_state_s = EXECUTER;
          7'b0010011:             next_state_s = EXECUTEI;
          7'b1101111:             next_state_s = JAL;
          7'b1100011:             next_state_s = BEQ;
`ifdef MCTRL_LUI_EN
          7'b0110111:             next_state_s = EXECUTELUI;
`endif
          default: begin
            next_state_s = FETCH;
            illegal_s    = 1'b1;
          end
        endcase
      end
      MEMADR: begin
        alusrca_s = 2'b10;
        alusrcb_s = 2'b01;
        if (opcode == 7'b0000011) begin
          next_state_s = MEMREAD;
        end else begin
          next_state_s = MEMWRITE;
        end
      end
      MEMREAD: begin
        adrsrc_s = 1'b1;
        if (mem_ready) begin
          next_state_s = MEMWB;
        end else begin
          next_state_s = MEMREAD;
        end
      end
      MEMWB: begin
        resultsrc_s  = 2'b01;
        regwrite_s   = 1'b1;
        next_state_s = FETCH;
      end
      MEMWRITE: begin
        adrsrc_s   = 1'b1;
        memwrite_s = 1'b1;
        if (mem_ready) begin
          next_state_s = FETCH;
        end else begin
          next_state_s = MEMWRITE;
        end
      end
      EXECUTER: begin
        alusrca_s    = 2'b10;
        aluop_s      = 2'b10;
        next_state_s = ALUWB;
      end
      EXECUTEI: begin
        alusrca_s    = 2'b10;
        alusrcb_s    = 2'b01;
        aluop_s      = 2'b10;
        next_state_s = ALUWB;
      end
      ALUWB: begin
        regwrite_s   = 1'b1;
        next_state_s = FETCH;
      end
      JAL: begin
        // PC takes the target from ALUOut while the ALU forms PC+4 for rd.
        alusrca_s    = 2'b01;
        alusrcb_s    = 2'b10;
        pcupdate_s   = 1'b1;
        next_state_s = ALUWB;
      end
      BEQ: begin
        alusrca_s    = 2'b10;
        aluop_s      = 2'b01;
        branch_s     = 1'b1;
        next_state_s = FETCH;
      end
`ifdef MCTRL_LUI_EN
      EXECUTELUI: begin
        alusrca_s    = 2'b11;
        alusrcb_s    = 2'b01;
        next_state_s = ALUWB;
      end
`endif
      default: begin
        next_state_s = FETCH;
      end
    endcase
  end

  // Enables are forced low while reset is held; selects already show FETCH values.
  assign PCWrite       = ~reset & ((Zero & branch_s) | pcupdate_s);
  assign IRWrite       = ~reset & irwrite_s;
  assign MemWrite      = ~reset & memwrite_s;
  assign RegWrite      = ~reset & regwrite_s;
  assign illegal_instr = ~reset & illegal_s;
  assign AdrSrc        = adrsrc_s;
  assign ResultSrc     = resultsrc_s;
  assign ALUSrcA       = alusrca_s;
  assign ALUSrcB       = alusrcb_s;
  assign ALUOp         = aluop_s;
  assign state         = state_r;

endmodule
